// File: rtl/gold_descrambler_if.sv
// gold_descrambler_if: stream and control bundle for gold_descrambler (o_seq present only with GOLD_DESCR_SEQ_OUT_EN)
interface gold_descrambler_if #(
  parameter int NBIT  = 8,
  parameter int LEN_W = 16
);
  logic             i_start;
  logic [30:0]      i_c_init;
  logic [LEN_W-1:0] i_len;
  logic             i_valid;
  logic [NBIT-1:0]  i_data;
  logic             o_ready;
  logic             o_valid;
  logic [NBIT-1:0]  o_data;
  logic             o_last;
  logic             i_ready;
  logic             o_busy;
  logic             o_done;
`ifdef GOLD_DESCR_SEQ_OUT_EN
  logic [NBIT-1:0]  o_seq;
`endif
  modport master (
    output i_start, i_c_init, i_len, i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_busy, o_done
`ifdef GOLD_DESCR_SEQ_OUT_EN
    , input o_seq
`endif
  );
  modport slave (
    input  i_start, i_c_init, i_len, i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_last, o_busy, o_done
`ifdef GOLD_DESCR_SEQ_OUT_EN
    , output o_seq
`endif
  );
endinterface

// File: rtl/gold_descrambler.sv
// gold_descrambler: streaming XOR with the 38.211 Gold sequence, NBIT bits/beat (GOLD_DESCR_SEQ_OUT_EN adds raw sequence output o_seq)
module gold_descrambler #(
  parameter int NBIT  = 8,
  parameter int LEN_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  gold_descrambler_if.slave bus
);
  localparam int WARM_N = 1600 / NBIT;
  localparam int TRIM_N = 1600 % NBIT;
  typedef enum logic [1:0] {IDLE, WARM, TRIM, RUN} state_t;
  state_t           state, state_nxt;
  logic [30:0]      x1, x2, x1_nxt, x2_nxt;
  logic [10:0]      cnt;
  logic [LEN_W-1:0] rem;
  logic             fin, acc, last_in, hand;
  logic [NBIT-1:0]  c, mask;
  assign c       = x1[NBIT-1:0] ^ x2[NBIT-1:0];
  assign last_in = rem <= LEN_W'(NBIT);
  assign acc     = bus.i_valid & bus.o_ready;
  assign hand    = fin & bus.o_valid & bus.i_ready;
  assign bus.o_ready = state == RUN && !fin && (!bus.o_valid || bus.i_ready);
  assign bus.o_busy  = state != IDLE;
  // Both LFSRs stepped serially: one step while trimming, NBIT steps otherwise; newest bit enters at the top
  always_comb begin
    x1_nxt = x1;
    x2_nxt = x2;
    for (int i = 0; i < NBIT; i++)
      if (i == 0 || state != TRIM) begin
        x1_nxt = {x1_nxt[3] ^ x1_nxt[0], x1_nxt[30:1]};
        x2_nxt = {x2_nxt[3] ^ x2_nxt[2] ^ x2_nxt[1] ^ x2_nxt[0], x2_nxt[30:1]};
      end
  end
  // Keep only the bits still inside the payload on the final beat
  always_comb begin
    mask = '0;
    for (int k = 0; k < NBIT; k++) mask[k] = LEN_W'(k) < rem;
  end
  // Frame sequencing: warm-up of 1600 steps, then streaming until the last beat is handed off
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = bus.i_start && bus.i_len != '0 ? WARM : IDLE;
      WARM:    state_nxt = cnt != '0 ? WARM : TRIM_N != 0 ? TRIM : RUN;
      TRIM:    state_nxt = cnt != '0 ? TRIM : RUN;
      default: state_nxt = hand ? IDLE : RUN;
    endcase
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  // Sequence state, length bookkeeping and the registered output beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x1          <= 31'h1;
      x2          <= '0;
      cnt         <= '0;
      rem         <= '0;
      fin         <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_last  <= 1'b0;
      bus.o_done  <= 1'b0;
    end else begin
      bus.o_done <= hand || (state == IDLE && bus.i_start && bus.i_len == '0);
      if (state == IDLE && bus.i_start) begin
        x1  <= 31'h1;
        x2  <= bus.i_c_init;
        rem <= bus.i_len;
        cnt <= 11'(WARM_N - 1);
      end
      if (state == WARM || state == TRIM || acc) begin
        x1 <= x1_nxt;
        x2 <= x2_nxt;
      end
      if (state == WARM) cnt <= cnt != '0 ? cnt - 11'd1 : 11'(TRIM_N - 1);
      if (state == TRIM) cnt <= cnt - 11'd1;
      if (acc) begin
        bus.o_valid <= 1'b1;
        bus.o_data  <= (bus.i_data ^ c) & mask;
        bus.o_last  <= last_in;
        rem         <= rem - (last_in ? rem : LEN_W'(NBIT));
        fin         <= last_in;
      end else if (bus.i_ready) begin
        bus.o_valid <= 1'b0;
        bus.o_last  <= 1'b0;
      end
      if (hand) fin <= 1'b0;
    end
`ifdef GOLD_DESCR_SEQ_OUT_EN
  // Raw sequence bits registered alongside o_data so they share its valid/hold behaviour
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   bus.o_seq <= '0;
    else if (acc) bus.o_seq <= c & mask;
`endif
endmodule

// File: tb/tb_gold_descrambler.sv
// tb_gold_descrambler: directed checks of gold_descrambler (NBIT=8 and NBIT=7) against a bit-serial Gold model
module tb_gold_descrambler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  gold_descrambler_if #(.NBIT(8), .LEN_W(16)) b8 ();
  gold_descrambler_if #(.NBIT(7), .LEN_W(16)) b7 ();
  gold_descrambler #(.NBIT(8), .LEN_W(16)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  gold_descrambler #(.NBIT(7), .LEN_W(16)) u7 (.clk(clk), .rst_n(rst_n), .bus(b7));
  logic        sel, start, v, rdy;
  logic [30:0] cinit;
  logic [15:0] len;
  logic [7:0]  din_w;
  logic        o_rdy, o_val, o_lst, o_dn, o_bsy;
  logic [7:0]  o_dat;
  assign b8.i_start  = start & !sel;
  assign b8.i_c_init = cinit;
  assign b8.i_len    = len;
  assign b8.i_valid  = v & !sel;
  assign b8.i_data   = din_w;
  assign b8.i_ready  = rdy;
  assign b7.i_start  = start & sel;
  assign b7.i_c_init = cinit;
  assign b7.i_len    = len;
  assign b7.i_valid  = v & sel;
  assign b7.i_data   = din_w[6:0];
  assign b7.i_ready  = rdy;
  assign o_rdy = sel ? b7.o_ready : b8.o_ready;
  assign o_val = sel ? b7.o_valid : b8.o_valid;
  assign o_lst = sel ? b7.o_last  : b8.o_last;
  assign o_dn  = sel ? b7.o_done  : b8.o_done;
  assign o_bsy = sel ? b7.o_busy  : b8.o_busy;
  assign o_dat = sel ? {1'b0, b7.o_data} : b8.o_data;
  int   checks = 0, failures = 0;
  logic gx1 [0:4095];
  logic gx2 [0:4095];
  logic gc  [0:2047];
  logic src [0:1023];
  logic res [0:1023];
  logic org [0:1023];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic gold(input logic [30:0] ci, input int n);
    for (int i = 0; i < 31; i++) begin
      gx1[i] = (i == 0);
      gx2[i] = ci[i];
    end
    for (int i = 31; i < 1600 + n; i++) begin
      gx1[i] = gx1[i-28] ^ gx1[i-31];
      gx2[i] = gx2[i-28] ^ gx2[i-29] ^ gx2[i-30] ^ gx2[i-31];
    end
    for (int i = 0; i < n; i++) gc[i] = gx1[i+1600] ^ gx2[i+1600];
  endtask
  task automatic run(input logic s, input logic [30:0] ci, input int n, input bit rnd,
                     input bit inj, input bit abort, input int warm_exp);
    int nbit, nb, w, idx, got, dones, hand_cyc, cyc, j;
    logic held_v, held_l;
    logic [7:0] held_d, e;
    nbit = s ? 7 : 8;
    nb = (n + nbit - 1) / nbit;
    gold(ci, n);
    @(negedge clk);
    sel = s; start = 1'b1; cinit = ci; len = n[15:0]; v = 1'b0; rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 1;
    while (!o_rdy && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("warmup", w - 1, warm_exp);
    idx = 0; got = 0; dones = 0; hand_cyc = -10; cyc = 0; held_v = 1'b0; held_l = 1'b0; held_d = '0;
    while (dones == 0 && cyc < 5000) begin
      if (abort && idx == 2) begin
        rst_n = 1'b0;
        #1;
        check("abort_zero", {o_val, o_rdy, o_lst, o_dn, o_bsy, o_dat}, 0);
        v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (o_dn) dones++;
        end
        check("abort_nodone", dones, 0);
        return;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      v = idx < nb;
      start = inj && idx == 1;
      len = inj && idx == 1 ? 16'd3 : n[15:0];
      for (int k = 0; k < 8; k++) din_w[k] = (idx * nbit + k < n) ? src[idx*nbit+k] : 1'b1;
      #1;
      if (held_v) begin
        check("hold_data", o_dat, held_d);
        check("hold_last", o_lst, held_l);
      end
      if (o_val && rdy) begin
        e = '0;
        for (int k = 0; k < nbit; k++) begin
          j = got * nbit + k;
          e[k] = j < n ? src[j] ^ gc[j] : 1'b0;
          if (j < n) res[j] = o_dat[k];
        end
        check("beat_data", o_dat, e);
        check("beat_last", o_lst, got == nb - 1);
        got++;
        hand_cyc = cyc;
      end
      held_v = o_val && !rdy;
      held_d = o_dat;
      held_l = o_lst;
      if (v && o_rdy) idx++;
      @(negedge clk);
      cyc++;
      if (o_dn) begin
        dones++;
        check("done_lat", cyc - hand_cyc, 1);
      end
    end
    v = 1'b0; start = 1'b0; rdy = 1'b1;
    check("beats", got, nb);
    check("accepts", idx, nb);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_dn) dones++;
    end
    check("done_once", dones, 1);
  endtask
  initial begin
    int mism;
    sel = 1'b0; start = 1'b0; v = 1'b0; rdy = 1'b0; cinit = '0; len = '0; din_w = '0;
    repeat (3) @(negedge clk);
    check("rst_u8", {b8.o_valid, b8.o_ready, b8.o_last, b8.o_done, b8.o_busy, b8.o_data}, 0);
    check("rst_u7", {b7.o_valid, b7.o_ready, b7.o_last, b7.o_done, b7.o_busy, b7.o_data}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) src[i] = 1'b0;
    run(1'b0, 31'h0, 32, 1'b0, 1'b0, 1'b0, 200);
    run(1'b0, 31'h0, 32, 1'b1, 1'b0, 1'b0, 200);
    for (int i = 0; i < 1024; i++) src[i] = 1'($urandom_range(0, 1));
    run(1'b1, 31'h12345, 20, 1'b0, 1'b0, 1'b0, 232);
    for (int i = 0; i < 1024; i++) org[i] = src[i];
    run(1'b0, 31'h5A5A5A5, 1000, 1'b0, 1'b0, 1'b0, 200);
    for (int i = 0; i < 1000; i++) src[i] = res[i];
    run(1'b0, 31'h5A5A5A5, 1000, 1'b1, 1'b0, 1'b0, 200);
    mism = 0;
    for (int i = 0; i < 1000; i++) if (res[i] !== org[i]) mism++;
    check("roundtrip", mism, 0);
    @(negedge clk);
    sel = 1'b0; start = 1'b1; len = 16'd0; cinit = 31'h1;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", o_dn, 1);
    check("len0_busy", {o_bsy, o_rdy}, 0);
    @(negedge clk);
    check("len0_done_off", {o_dn, o_bsy, o_rdy}, 0);
    run(1'b0, 31'h777, 40, 1'b0, 1'b1, 1'b0, 200);
    run(1'b0, 31'h333, 32, 1'b0, 1'b0, 1'b1, 200);
    run(1'b0, 31'h444, 32, 1'b0, 1'b0, 1'b0, 200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
